// File: rtl/count_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : count_sampler
//  Description : Captures a counter value (plus a wrapped-since-last-sample
//                flag) on each sample strobe into a show-ahead FIFO that
//                drains to a valid/ready consumer; drops raise a sticky flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_sampler #(
    parameter int SIZE       = 5,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SIZE-1:0]       count_in,
    input  logic                  sample,
    output logic [SIZE-1:0]       out_count,
    output logic                  out_wrap,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clear_ovf
);

    localparam int                   c_DEPTH_N   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  c_DEPTH     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]  c_LVL_ZERO  = '0;
    localparam logic [DEPTH_LOG2:0]  c_LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [SIZE:0]            r_mem [c_DEPTH_N];
    logic [DEPTH_LOG2-1:0]    r_wr_ptr;
    logic [DEPTH_LOG2-1:0]    r_rd_ptr;
    logic [DEPTH_LOG2:0]      r_level;
    logic [SIZE-1:0]          r_prev_count;
    logic                     r_wrap_pending;
    logic                     r_overflow;
    logic [SIZE-1:0]          r_out_count;
    logic                     r_out_wrap;

    logic                     w_wrap_now;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [SIZE:0]            w_entry;
    logic [DEPTH_LOG2-1:0]    w_rd_next;
    logic [DEPTH_LOG2:0]      w_level_next;
    logic                     w_head_load;
    logic [SIZE:0]            w_head_next;

    assign w_wrap_now = (count_in < r_prev_count);
    assign w_pop      = (r_level != c_LVL_ZERO) & out_ready;
    assign w_push     = sample & ((r_level < c_DEPTH) | w_pop);
    assign w_drop     = sample & ~w_push;
    assign w_entry    = {count_in, r_wrap_pending | w_wrap_now};
    assign w_rd_next  = r_rd_ptr + c_PTR_ONE;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + c_LVL_ONE;
            2'b01:   w_level_next = r_level - c_LVL_ONE;
            default: w_level_next = r_level;
        endcase
    end

    // The head register mirrors mem[rd_ptr]; a push that lands directly at
    // the head bypasses the memory since it is not written until this edge.
    always_comb begin
        w_head_load = 1'b0;
        w_head_next = w_entry;
        if (w_push && ((r_level == c_LVL_ZERO) || (w_pop && (r_level == c_LVL_ONE)))) begin
            w_head_load = 1'b1;
        end else if (w_pop && (r_level > c_LVL_ONE)) begin
            w_head_load = 1'b1;
            w_head_next = r_mem[w_rd_next];
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_prev_count   <= '0;
            r_wrap_pending <= 1'b0;
            r_overflow     <= 1'b0;
            r_out_count    <= '0;
            r_out_wrap     <= 1'b0;
        end else begin
            r_prev_count <= count_in;
            // An accepted sample consumes any pending wrap, including this cycle's.
            if (w_push) begin
                r_wrap_pending <= 1'b0;
            end else if (w_wrap_now) begin
                r_wrap_pending <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_level <= w_level_next;
            if (w_head_load) begin
                {r_out_count, r_out_wrap} <= w_head_next;
            end
        end
    end

    assign out_count = r_out_count;
    assign out_wrap  = r_out_wrap;
    assign out_valid = (r_level != c_LVL_ZERO);
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_count_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_sampler
//  Description : Directed, table-driven bench for count_sampler (SIZE=5,
//                DEPTH_LOG2=2) with hand-written reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sampler;

    logic       clock;
    logic       reset;
    logic [4:0] count_in;
    logic       sample;
    logic [4:0] out_count;
    logic       out_wrap;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;
    logic       clear_ovf;

    int n_total = 0;
    int n_pass  = 0;

    count_sampler #(.SIZE(5), .DEPTH_LOG2(2)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .count_in  (count_in),
        .sample    (sample),
        .out_count (out_count),
        .out_wrap  (out_wrap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       smp;
        logic [4:0] cnt;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [4:0] ec;
        logic       ew;
        logic [2:0] el;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic smp, input int cnt, input logic rdy, input logic clr,
                               input logic ev, input int ec, input logic ew, input int el,
                               input logic eo);
        vec_t r;
        r.smp = smp; r.cnt = cnt[4:0]; r.rdy = rdy; r.clr = clr;
        r.ev  = ev;  r.ec  = ec[4:0];  r.ew  = ew;  r.el  = el[2:0]; r.eo = eo;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic chk_state(input string tag, input logic ev, input logic [4:0] ec,
                             input logic ew, input logic [2:0] el, input logic eo);
        chk({tag, " out_valid"}, {7'd0, out_valid}, {7'd0, ev});
        chk({tag, " level"},     {5'd0, level},     {5'd0, el});
        chk({tag, " overflow"},  {7'd0, overflow},  {7'd0, eo});
        if (ev) begin
            chk({tag, " out_count"}, {3'd0, out_count}, {3'd0, ec});
            chk({tag, " out_wrap"},  {7'd0, out_wrap},  {7'd0, ew});
        end
    endtask

    task automatic step(input logic smp, input logic [4:0] cnt, input logic rdy, input logic clr);
        sample = smp; count_in = cnt; out_ready = rdy; clear_ovf = clr;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // single sample, consume
        vecs.push_back(v(1,  7, 0, 0,  1,  7, 0, 1, 0));
        vecs.push_back(v(0,  7, 1, 0,  0,  0, 0, 0, 0));
        // counter wraps between samples
        vecs.push_back(v(0, 29, 0, 0,  0,  0, 0, 0, 0));
        vecs.push_back(v(0, 30, 0, 0,  0,  0, 0, 0, 0));
        vecs.push_back(v(0, 31, 0, 0,  0,  0, 0, 0, 0));
        vecs.push_back(v(0,  0, 0, 0,  0,  0, 0, 0, 0));
        vecs.push_back(v(1,  1, 0, 0,  1,  1, 1, 1, 0));
        vecs.push_back(v(0,  2, 1, 0,  0,  0, 0, 0, 0));
        vecs.push_back(v(1,  3, 0, 0,  1,  3, 0, 1, 0));
        vecs.push_back(v(0,  3, 1, 0,  0,  0, 0, 0, 0));
        // fill past full; 2 < prev 3 so the first entry carries a same-cycle wrap
        vecs.push_back(v(1,  2, 0, 0,  1,  2, 1, 1, 0));
        vecs.push_back(v(1,  3, 0, 0,  1,  2, 1, 2, 0));
        vecs.push_back(v(1,  4, 0, 0,  1,  2, 1, 3, 0));
        vecs.push_back(v(1,  5, 0, 0,  1,  2, 1, 4, 0));
        vecs.push_back(v(1,  6, 0, 0,  1,  2, 1, 4, 1));
        // clear with simultaneous drop, then plain clear
        vecs.push_back(v(1,  6, 0, 1,  1,  2, 1, 4, 1));
        vecs.push_back(v(0,  6, 0, 1,  1,  2, 1, 4, 0));
        // full FIFO push+pop, then drain showing new tail
        vecs.push_back(v(1,  8, 1, 0,  1,  3, 0, 4, 0));
        vecs.push_back(v(0,  8, 1, 0,  1,  4, 0, 3, 0));
        vecs.push_back(v(0,  8, 1, 0,  1,  5, 0, 2, 0));
        vecs.push_back(v(0,  8, 1, 0,  1,  8, 0, 1, 0));
        vecs.push_back(v(0,  8, 1, 0,  0,  0, 0, 0, 0));
        // push+pop at level 1 bypasses to the head
        vecs.push_back(v(1, 10, 0, 0,  1, 10, 0, 1, 0));
        vecs.push_back(v(1, 11, 1, 0,  1, 11, 0, 1, 0));
        vecs.push_back(v(0, 11, 1, 0,  0,  0, 0, 0, 0));
        vecs.push_back(v(1,  2, 0, 0,  1,  2, 1, 1, 0));
        vecs.push_back(v(0,  2, 1, 0,  0,  0, 0, 0, 0));
        // a wrap seen on a dropped sample stays pending for the next accepted one
        vecs.push_back(v(1,  3, 0, 0,  1,  3, 0, 1, 0));
        vecs.push_back(v(1,  4, 0, 0,  1,  3, 0, 2, 0));
        vecs.push_back(v(1,  5, 0, 0,  1,  3, 0, 3, 0));
        vecs.push_back(v(1,  6, 0, 0,  1,  3, 0, 4, 0));
        vecs.push_back(v(1,  1, 0, 0,  1,  3, 0, 4, 1));
        vecs.push_back(v(0,  2, 1, 0,  1,  4, 0, 3, 1));
        vecs.push_back(v(1,  2, 0, 1,  1,  4, 0, 4, 0));
        vecs.push_back(v(0,  2, 1, 0,  1,  5, 0, 3, 0));
        vecs.push_back(v(0,  2, 1, 0,  1,  6, 0, 2, 0));
        vecs.push_back(v(0,  2, 1, 0,  1,  2, 1, 1, 0));
        vecs.push_back(v(0,  2, 1, 0,  0,  0, 0, 0, 0));
        // ready on empty has no effect
        vecs.push_back(v(0,  2, 1, 0,  0,  0, 0, 0, 0));

        reset = 1'b0; count_in = '0; sample = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_state("reset", 1'b0, 5'd0, 1'b0, 3'd0, 1'b0);
        chk("reset out_count", {3'd0, out_count}, 8'd0);
        chk("reset out_wrap",  {7'd0, out_wrap},  8'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].smp, vecs[i].cnt, vecs[i].rdy, vecs[i].clr);
            chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ew,
                      vecs[i].el, vecs[i].eo);
        end

        // mid-run asynchronous reset with three entries queued and overflow set
        for (int c = 20; c < 25; c++) step(1'b1, 5'(c), 1'b0, 1'b0);
        step(1'b0, 5'd24, 1'b1, 1'b0);
        chk_state("prereset", 1'b1, 5'd21, 1'b0, 3'd3, 1'b1);
        out_ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk_state("async_reset", 1'b0, 5'd0, 1'b0, 3'd0, 1'b0);
        chk("async_reset out_count", {3'd0, out_count}, 8'd0);
        chk("async_reset out_wrap",  {7'd0, out_wrap},  8'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // post-reset sample: history was discarded, so no wrap reported
        step(1'b1, 5'd9, 1'b0, 1'b0);
        chk_state("post_reset", 1'b1, 5'd9, 1'b0, 3'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
